// File: rtl/mul_chain_sched.sv
// mul_chain_sched: sequences one operand batch at a time through the six-lane multiplier chain
module mul_chain_sched #(
    parameter int STAGE_LAT = 3,
    parameter int TIMEOUT   = 16,
    parameter int TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [383:0]     in_ops,
    input  logic [TAG_W-1:0] in_tag,
    output logic [383:0]     mc_ins,
    output logic [1:0]       mc_mode,
    output logic             mc_stb,
    input  logic [191:0]     mc_outputs,
    input  logic [5:0]       mc_final_stbs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [191:0]     out_data,
    output logic [2:0]       out_count,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy,
    output logic [15:0]      batch_cnt
);
    localparam int CW = $clog2(5 * STAGE_LAT + TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nom;
    logic [5:0]    mask;
    logic [191:0]  cmp;
    logic [2:0]    cmp_count;
    logic          hit;
    logic          expired;

    assign busy = state != IDLE;

    // Mode-dependent latency, completion mask and lane-to-slot compaction of the chain results
    always_comb begin
        nom = CW'(STAGE_LAT) * (mc_mode == 2'd0 ? CW'(1) : mc_mode == 2'd1 ? CW'(2) : mc_mode == 2'd2 ? CW'(3) : CW'(5));
        mask = mc_mode == 2'd0 ? 6'b111111 : mc_mode == 2'd1 ? 6'b101010 : mc_mode == 2'd2 ? 6'b100100 : 6'b010000;
        cmp = mc_mode == 2'd0 ? mc_outputs
            : mc_mode == 2'd1 ? {96'd0, mc_outputs[191:160], mc_outputs[127:96], mc_outputs[63:32]}
            : mc_mode == 2'd2 ? {128'd0, mc_outputs[191:160], mc_outputs[95:64]}
            : {160'd0, mc_outputs[159:128]};
        cmp_count = mc_mode == 2'd0 ? 3'd6 : mc_mode == 2'd1 ? 3'd3 : mc_mode == 2'd2 ? 3'd2 : 3'd1;
        // Strobes before the nominal latency are stale or partial and must not complete the batch
        hit = cnt >= nom && (mc_final_stbs & mask) == mask;
        expired = cnt == nom + CW'(TIMEOUT);
    end

    // Accept a batch, hold the chain inputs through RUN, then present the result until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            mc_stb    <= 1'b0;
            mc_ins    <= '0;
            mc_mode   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            batch_cnt <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= RUN;
                    in_ready <= 1'b0;
                    mc_stb   <= 1'b1;
                    mc_ins   <= in_ops;
                    mc_mode  <= in_mode;
                    out_tag  <= in_tag;
                    cnt      <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (hit || expired) begin
                        state     <= OUT;
                        mc_stb    <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= cmp;
                        out_count <= cmp_count;
                        out_err   <= !hit;
                    end
                end
                OUT: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    batch_cnt <= batch_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_chain_sched.sv
// tb_mul_chain_sched: directed batches against a chain model and a per-cycle reference of the scheduler
module tb_mul_chain_sched;
    localparam int MI = 0, MR = 1, MO = 2;

    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [1:0]   in_mode = 0;
    logic [383:0] in_ops = 0;
    logic [7:0]   in_tag = 0;
    logic         in_ready, mc_stb, out_valid, out_err, busy;
    logic [383:0] mc_ins;
    logic [1:0]   mc_mode;
    logic [191:0] mc_outputs, out_data;
    logic [5:0]   mc_final_stbs;
    logic [2:0]   out_count;
    logic [7:0]   out_tag;
    logic [15:0]  batch_cnt;

    mul_chain_sched #(.STAGE_LAT(3), .TIMEOUT(16), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_ops(in_ops), .in_tag(in_tag), .mc_ins(mc_ins), .mc_mode(mc_mode), .mc_stb(mc_stb),
        .mc_outputs(mc_outputs), .mc_final_stbs(mc_final_stbs), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_tag(out_tag),
        .out_err(out_err), .busy(busy), .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [5:0] mask_of(input logic [1:0] m);
        return m == 0 ? 6'b111111 : m == 1 ? 6'b101010 : m == 2 ? 6'b100100 : 6'b010000;
    endfunction

    function automatic int depth_of(input logic [1:0] m);
        return m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 3 : 5;
    endfunction

    // Chain model: lane n strobes and shows its value from cycle lane_from[n] of the strobe run
    logic [31:0] vals [6];
    int          lane_from [6];
    logic [5:0]  early_stbs = 0;
    int          early_k = -1;
    int          k = 0;

    always @(posedge clk) k <= mc_stb ? k + 1 : 0;

    always_comb begin
        mc_final_stbs = '0;
        mc_outputs = '0;
        for (int n = 0; n < 6; n++) begin
            mc_outputs[32*n +: 32] = k >= lane_from[n] ? vals[n] : 32'hDEADBEEF;
            if (mc_stb && k >= lane_from[n]) mc_final_stbs[n] = 1'b1;
        end
        if (mc_stb && k == early_k) mc_final_stbs = mc_final_stbs | early_stbs;
        mc_final_stbs = mc_final_stbs & mask_of(mc_mode);
    end

    // Outcome of a batch: finishing cycle, error flag and compacted slots
    function automatic void predict(input logic [1:0] m, output int due, output logic err,
                                    output logic [191:0] data, output logic [2:0] cnt);
        int nom, c, ln;
        nom = 3 * depth_of(m);
        c = nom;
        for (int n = 0; n < 6; n++) if (mask_of(m)[n] && lane_from[n] > c) c = lane_from[n];
        err = c > nom + 16;
        if (err) c = nom + 16;
        cnt = m == 0 ? 3'd6 : m == 1 ? 3'd3 : m == 2 ? 3'd2 : 3'd1;
        data = '0;
        for (int s = 0; s < int'(cnt); s++) begin
            ln = m == 0 ? s : m == 1 ? 2 * s + 1 : m == 2 ? 3 * s + 2 : 4;
            data[32*s +: 32] = c >= lane_from[ln] ? vals[ln] : 32'hDEADBEEF;
        end
        due = c;
    endfunction

    // Reference: phase and elapsed cycles since acceptance
    int           m_phase, m_t, m_due, p_due;
    logic         m_err, p_err;
    logic [383:0] m_ops;
    logic [1:0]   m_mode;
    logic [7:0]   m_tag;
    logic [191:0] m_data, p_data;
    logic [2:0]   m_count, p_count;
    logic [15:0]  m_batches;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= MI;
            m_batches <= 0;
        end else if (m_phase == MI) begin
            if (in_valid) begin
                predict(in_mode, p_due, p_err, p_data, p_count);
                m_phase <= MR;
                m_t <= 0;
                m_ops <= in_ops;
                m_mode <= in_mode;
                m_tag <= in_tag;
                m_due <= p_due;
                m_err <= p_err;
                m_data <= p_data;
                m_count <= p_count;
            end
        end else if (m_phase == MR) begin
            m_t <= m_t + 1;
            if (m_t == m_due) m_phase <= MO;
        end else if (out_ready) begin
            m_phase <= MI;
            m_batches <= m_batches + 1;
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, m_phase == MI);
        check("mc_stb", mc_stb, m_phase == MR);
        check("busy", busy, m_phase != MI);
        check("out_valid", out_valid, m_phase == MO);
        check("batch_cnt", batch_cnt, m_batches);
        if (m_phase == MR) begin
            check("mc_ins", mc_ins, m_ops);
            check("mc_mode", mc_mode, m_mode);
        end
        if (m_phase == MO) begin
            check("out_data", out_data, m_data);
            check("out_count", out_count, m_count);
            check("out_tag", out_tag, m_tag);
            check("out_err", out_err, m_err);
        end
    end

    task automatic set_chain(input int lat, input logic [31:0] v0, v1, v2, v3, v4, v5);
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3; vals[4] = v4; vals[5] = v5;
        for (int n = 0; n < 6; n++) lane_from[n] = lat;
        early_k = -1;
        early_stbs = 0;
    endtask

    task automatic offer(input logic [1:0] m, input logic [383:0] ops, input logic [7:0] tag);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("offer_ready", in_ready, 1);
        in_mode = m;
        in_ops = ops;
        in_tag = tag;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        in_mode = ~m;
        in_ops = ~ops;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_out();
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        set_chain(3, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000);
        #2 rst = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mc_stb", mc_stb, 0);
        check("rst_mc_ins", mc_ins, 0);
        check("rst_mc_mode", mc_mode, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_batch_cnt", batch_cnt, 0);
        rst = 1;
        @(negedge clk);

        offer(2'd0, {6{32'h40400000, 32'h40000000}}, 8'h11);
        wait_out(lat);
        check("two_in_lat", lat, 4);
        check("two_in_data", out_data, {6{32'h40C00000}});
        check("two_in_count", out_count, 6);
        check("two_in_tag", out_tag, 8'h11);
        check("two_in_err", out_err, 0);
        take_out();
        check("two_in_batch_cnt", batch_cnt, 1);

        set_chain(15, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h42800000, 32'h40800000);
        offer(2'd3, {6{32'h40000000, 32'h40000000}}, 8'h22);
        wait_out(lat);
        check("six_in_lat", lat, 16);
        check("six_in_data", out_data, {160'd0, 32'h42800000});
        check("six_in_count", out_count, 1);
        take_out();

        set_chain(6, 32'h3F800000, 32'h40C00000, 32'h3F800000, 32'h41000000, 32'h3F800000, 32'h40800000);
        early_k = 3;
        early_stbs = 6'b101010;
        offer(2'd1, {32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                     32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 8'h33);
        wait_out(lat);
        check("three_in_lat", lat, 7);
        check("three_in_data", out_data, {96'd0, 32'h40800000, 32'h41000000, 32'h40C00000});
        check("three_in_count", out_count, 3);
        take_out();

        set_chain(9, 32'h0, 32'h0, 32'h40400000, 32'h0, 32'h0, 32'h41200000);
        lane_from[5] = 99;
        offer(2'd2, {6{32'h3FC00000, 32'h40000000}}, 8'h44);
        wait_out(lat);
        check("timeout_lat", lat, 26);
        check("timeout_err", out_err, 1);
        check("timeout_count", out_count, 2);
        check("timeout_data", out_data, {128'd0, 32'hDEADBEEF, 32'h40400000});
        take_out();

        set_chain(3, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000);
        offer(2'd0, {6{32'h40400000, 32'h40000000}}, 8'h55);
        wait_out(lat);
        in_mode = 2'd2;
        in_ops = {6{32'h40000000, 32'h40400000}};
        in_tag = 8'h66;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_tag", out_tag, 8'h55);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check("bubble_in_ready", in_ready, 1);
        check("bubble_busy", busy, 0);
        @(posedge clk);
        #1 in_valid = 0;
        wait_out(lat);
        check("second_lat", lat, 10);
        check("second_tag", out_tag, 8'h66);
        take_out();

        set_chain(15, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h42800000, 32'h40800000);
        offer(2'd3, {6{32'h40000000, 32'h40000000}}, 8'h77);
        repeat (5) @(negedge clk);
        #2 rst = 0;
        #1;
        check("abort_mc_stb", mc_stb, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_batch_cnt", batch_cnt, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        set_chain(3, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000);
        offer(2'd0, {6{32'h40400000, 32'h40000000}}, 8'h88);
        wait_out(lat);
        check("after_rst_lat", lat, 4);
        check("after_rst_data", out_data, {6{32'h40C00000}});
        take_out();
        check("after_rst_batch_cnt", batch_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
